// File: rtl/card_cycle_pkg.sv
// card_cycle_pkg: shared states, row codes and angle constants for the card cycle controller
package card_cycle_pkg;
  typedef enum logic [1:0] {IDLE, ENGAGE, READ, FINISH} state_t;
  localparam int ROW_COUNT = 12;
  localparam int DEFAULT_LATCH_ANGLE = 315;
  localparam int ANGLE_W = 9;
  localparam logic [3:0] ROW_9 = 4'd0;
  localparam logic [3:0] ROW_8 = 4'd1;
  localparam logic [3:0] ROW_7 = 4'd2;
  localparam logic [3:0] ROW_6 = 4'd3;
  localparam logic [3:0] ROW_5 = 4'd4;
  localparam logic [3:0] ROW_4 = 4'd5;
  localparam logic [3:0] ROW_3 = 4'd6;
  localparam logic [3:0] ROW_2 = 4'd7;
  localparam logic [3:0] ROW_1 = 4'd8;
  localparam logic [3:0] ROW_0 = 4'd9;
  localparam logic [3:0] ROW_11 = 4'd10;
  localparam logic [3:0] ROW_12 = 4'd11;
endpackage

// File: rtl/card_cycle_ctrl_sccb_edge_det.sv
// sccb_edge_det: registered rising-edge detector for the brush strobe
module sccb_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic sccb,
  output logic rise
);
  logic prev;
  // previous strobe level, tracked regardless of power
  always_ff @(posedge clk) prev <= reset ? 1'b0 : sccb;
  assign rise = sccb & ~prev;
endmodule

// File: rtl/card_cycle_ctrl.sv
// card_cycle_ctrl: clutch latch, engagement timeout and row sampling per card; CARD_CYCLE_ROW_PARITY_EN adds row_par/blank_card
module card_cycle_ctrl
  import card_cycle_pkg::*;
#(
  parameter int COLS = 80,
  parameter int ENGAGE_TIMEOUT = 400,
  parameter int LATCH_ANGLE = DEFAULT_LATCH_ANGLE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               power,
  input  logic               feed_req,
  input  logic [ANGLE_W-1:0] clch_angle,
  input  logic               sccb,
  input  logic [COLS-1:0]    brush,
  output logic               clch_latch,
  output logic               busy,
  output logic               row_valid,
  output logic [3:0]         row_num,
  output logic [COLS-1:0]    row_data,
  output logic               cycle_done,
  output logic               eng_err
`ifdef CARD_CYCLE_ROW_PARITY_EN
  ,
  output logic               row_par,
  output logic               blank_card
`endif
);
  localparam int TW = $clog2(ENGAGE_TIMEOUT + 1);
  state_t state, state_n;
  logic [TW-1:0] tmo, tmo_n;
  logic [3:0] cnt, cnt_n;
  logic latch_n, err_n, rise, engaged, at_rest, take;
  sccb_edge_det u_edge (.clk(clk), .reset(reset), .sccb(sccb), .rise(rise));
  assign engaged = power && clch_angle == ANGLE_W'(LATCH_ANGLE + 1);
  assign at_rest = power && clch_angle == ANGLE_W'(LATCH_ANGLE);
  assign take = power && state == READ && rise;
  assign busy = state != IDLE;
  assign cycle_done = state == FINISH && at_rest;
  // next state, timeout, row counter, latch and error flag
  always_comb begin
    state_n = state;
    tmo_n = tmo;
    cnt_n = cnt;
    latch_n = clch_latch;
    err_n = eng_err;
    if (state == IDLE) begin
      if (feed_req) begin
        state_n = ENGAGE;
        latch_n = 1'b1;
        tmo_n = TW'(ENGAGE_TIMEOUT);
        err_n = 1'b0;
      end
    end else if (state == ENGAGE && power) begin
      if (engaged) begin
        state_n = READ;
        cnt_n = 4'd0;
      end else if (tmo <= TW'(1)) begin
        state_n = IDLE;
        latch_n = 1'b0;
        err_n = 1'b1;
      end else
        tmo_n = tmo - 1'b1;
    end else if (state == READ && take) begin
      if (cnt == ROW_12) begin
        state_n = FINISH;
        latch_n = feed_req;
      end else
        cnt_n = cnt + 4'd1;
    end else if (state == FINISH && at_rest) begin
      cnt_n = 4'd0;
      state_n = clch_latch ? READ : IDLE;
    end
  end
  // control state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      tmo <= '0;
      cnt <= 4'd0;
      clch_latch <= 1'b0;
      eng_err <= 1'b0;
    end else begin
      state <= state_n;
      tmo <= tmo_n;
      cnt <= cnt_n;
      clch_latch <= latch_n;
      eng_err <= err_n;
    end
  end
  // row sample register, presented the clock after the strobe edge
  always_ff @(posedge clk) begin
    if (reset) begin
      row_valid <= 1'b0;
      row_num <= 4'd0;
      row_data <= '0;
    end else begin
      row_valid <= take;
      if (take) begin
        row_num <= cnt;
        row_data <= brush;
      end
    end
  end
`ifdef CARD_CYCLE_ROW_PARITY_EN
  logic any_hole;
  // row parity and blank-card detection over the 12 rows of a card
  always_ff @(posedge clk) begin
    if (reset) begin
      row_par <= 1'b0;
      any_hole <= 1'b0;
      blank_card <= 1'b0;
    end else begin
      if (take) row_par <= ^brush;
      if (state == IDLE && feed_req) begin
        any_hole <= 1'b0;
        blank_card <= 1'b0;
      end else if (take) begin
        any_hole <= (cnt == ROW_9 ? 1'b0 : any_hole) | (|brush);
        if (cnt == ROW_9) blank_card <= 1'b0;
      end
      if (cycle_done) blank_card <= ~any_hole;
    end
  end
`endif
endmodule

// File: tb/tb_card_cycle_ctrl.sv
// tb_card_cycle_ctrl: directed checks of card_cycle_ctrl against a simple clutch/cam model
module tb_card_cycle_ctrl;
  logic clk = 0, reset = 1, power = 1, feed_req = 0;
  logic [8:0] ang = 9'd315, fixed_ang = 9'd315;
  logic clutch_model = 1;
  logic [8:0] clch_angle;
  logic sccb;
  logic [79:0] brush;
  logic clch_latch, busy, row_valid, cycle_done, eng_err;
  logic [3:0] row_num;
  logic [79:0] row_data;
`ifdef CARD_CYCLE_ROW_PARITY_EN
  logic row_par, blank_card;
`endif
  logic [79:0] row_pat [12];
  int total = 0, fails = 0;
  int rv_cnt = 0, cd_cnt = 0, falls = 0, cd_ang = 0;
  logic prev_latch = 0;
  logic [3:0] rec_num [128];
  logic [79:0] rec_data [128];
  int rec_ang [128];
  int base, cbase, fbase, k;

  card_cycle_ctrl dut (
    .clk(clk), .reset(reset), .power(power), .feed_req(feed_req),
    .clch_angle(clch_angle), .sccb(sccb), .brush(brush),
    .clch_latch(clch_latch), .busy(busy), .row_valid(row_valid),
    .row_num(row_num), .row_data(row_data), .cycle_done(cycle_done),
    .eng_err(eng_err)
`ifdef CARD_CYCLE_ROW_PARITY_EN
    , .row_par(row_par), .blank_card(blank_card)
`endif
  );

  always #5 clk = ~clk;

  // clutch rests at 315 unless latched, otherwise turns one degree per powered clock
  always @(posedge clk)
    if (clutch_model && power)
      ang <= (ang == 9'd315 && !clch_latch) ? 9'd315 : (ang == 9'd359 ? 9'd0 : ang + 9'd1);

  assign clch_angle = clutch_model ? ang : fixed_ang;

  // strobes at 12,30,...,210 degrees, brush shows that row's pattern during its strobe
  always_comb begin
    int a;
    a = int'(clch_angle);
    sccb = clutch_model && a >= 12 && a <= 210 && (a - 12) % 18 == 0;
    brush = sccb ? row_pat[(a - 12) / 18] : '0;
  end

  always @(negedge clk) begin
    if (row_valid && rv_cnt < 128) begin
      rec_num[rv_cnt] = row_num;
      rec_data[rv_cnt] = row_data;
      rec_ang[rv_cnt] = int'(clch_angle);
    end
    if (row_valid) rv_cnt++;
    if (cycle_done) begin
      cd_cnt++;
      cd_ang = int'(clch_angle);
    end
    if (prev_latch && !clch_latch) falls++;
    prev_latch = clch_latch;
  end

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_feed();
    feed_req = 1;
    @(negedge clk);
    feed_req = 0;
  endtask

  initial begin
    for (int i = 0; i < 12; i++) row_pat[i] = (i == 0) ? 80'h1 : 80'h0;
    repeat (3) @(negedge clk);
    reset = 0;
    chk("rst_latch", 80'(clch_latch), 80'd0);
    chk("rst_busy", 80'(busy), 80'd0);
    chk("rst_valid", 80'(row_valid), 80'd0);
    chk("rst_num", 80'(row_num), 80'd0);
    chk("rst_data", row_data, 80'd0);
    chk("rst_done", 80'(cycle_done), 80'd0);
    chk("rst_err", 80'(eng_err), 80'd0);
    // single card, hole only in row 9
    base = rv_cnt; cbase = cd_cnt; fbase = falls;
    pulse_feed();
    chk("sc_latch_on", 80'(clch_latch), 80'd1);
    chk("sc_busy", 80'(busy), 80'd1);
    for (k = 0; k < 1000 && cd_cnt - cbase < 1; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("sc_rows", 80'(rv_cnt - base), 80'd12);
    chk("sc_done", 80'(cd_cnt - cbase), 80'd1);
    chk("sc_done_ang", 80'(cd_ang), 80'd315);
    chk("sc_falls", 80'(falls - fbase), 80'd1);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("sc_num%0d", i), 80'(rec_num[base + i]), 80'(i));
      chk($sformatf("sc_data%0d", i), rec_data[base + i], i == 0 ? 80'h1 : 80'h0);
      chk($sformatf("sc_ang%0d", i), 80'(rec_ang[base + i]), 80'(13 + 18 * i));
    end
    chk("sc_idle", 80'(busy), 80'd0);
    chk("sc_latch_off", 80'(clch_latch), 80'd0);
    // three back-to-back cards
    for (int i = 0; i < 12; i++) row_pat[i] = 80'(i + 1) << (i * 6);
    base = rv_cnt; cbase = cd_cnt; fbase = falls;
    feed_req = 1;
    for (k = 0; k < 3000 && rv_cnt - base < 33; k++) @(negedge clk);
    feed_req = 0;
    for (k = 0; k < 1000 && cd_cnt - cbase < 3; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("bb_rows", 80'(rv_cnt - base), 80'd36);
    chk("bb_done", 80'(cd_cnt - cbase), 80'd3);
    chk("bb_falls", 80'(falls - fbase), 80'd1);
    chk("bb_c2_first", 80'(rec_num[base + 12]), 80'd0);
    chk("bb_c3_last", 80'(rec_num[base + 35]), 80'd11);
    chk("bb_c3_data5", rec_data[base + 29], 80'd6 << 30);
    chk("bb_idle", 80'(busy), 80'd0);
    // engagement timeout with the clutch stuck at rest
    clutch_model = 0;
    fixed_ang = 9'd315;
    pulse_feed();
    chk("to_latch_on", 80'(clch_latch), 80'd1);
    for (k = 0; k < 1000 && !eng_err; ) begin
      @(negedge clk);
      k++;
    end
    chk("to_clocks", 80'(k), 80'd400);
    chk("to_err", 80'(eng_err), 80'd1);
    chk("to_latch_off", 80'(clch_latch), 80'd0);
    chk("to_idle", 80'(busy), 80'd0);
    // power stall extends the timeout by the stalled clocks
    pulse_feed();
    chk("ps_err_clr", 80'(eng_err), 80'd0);
    repeat (300) @(negedge clk);
    power = 0;
    repeat (50) @(negedge clk);
    power = 1;
    repeat (99) @(negedge clk);
    chk("ps_no_err", 80'(eng_err), 80'd0);
    chk("ps_busy", 80'(busy), 80'd1);
    fixed_ang = 9'd316;
    @(negedge clk);
    chk("ps_engaged_err", 80'(eng_err), 80'd0);
    chk("ps_engaged_latch", 80'(clch_latch), 80'd1);
    chk("ps_engaged_busy", 80'(busy), 80'd1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    clutch_model = 1;
    // reset mid-cycle after row 5
    base = rv_cnt;
    pulse_feed();
    for (k = 0; k < 1000 && rv_cnt - base < 6; k++) @(negedge clk);
    chk("mr_rows_before", 80'(rv_cnt - base), 80'd6);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("mr_latch", 80'(clch_latch), 80'd0);
    chk("mr_busy", 80'(busy), 80'd0);
    chk("mr_valid", 80'(row_valid), 80'd0);
    chk("mr_num", 80'(row_num), 80'd0);
    chk("mr_data", row_data, 80'd0);
    chk("mr_err", 80'(eng_err), 80'd0);
    for (k = 0; k < 500 && ang != 9'd315; k++) @(negedge clk);
    chk("mr_ignored", 80'(rv_cnt - base), 80'd6);
    base = rv_cnt;
    pulse_feed();
    for (k = 0; k < 500 && rv_cnt - base < 1; k++) @(negedge clk);
    chk("mr_restart_num", 80'(rec_num[base]), 80'd0);
    chk("mr_restart_data", rec_data[base], row_pat[0]);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
